pooling_row_scheduler: RTL and testbench
========================================

# pooling_row_scheduler

Transmit-side sequencer for the pooling layer's feature stream. It accepts one completed convolution output row at a time from upstream, then issues that row to the pooling controller once per feature map. Each issue is a single-cycle `input_valid` strobe with a stable `feature_idx`/`feature_row`, spaced so that each compare window finishes before the next issue. It sits between the convolution row buffer and the pooling controller, and owns row ordering and frame wrap-around.

## Interface
Parameters:
- `INPUT_SIZE`, 6, rows per feature map (pooling input height)
- `KERNEL_SIZE`, 2, pooling kernel size; sets issue spacing
- `TOTAL_FEATURE`, 4, feature maps issued per row

Ports (widths: `FW` = clog2(`TOTAL_FEATURE`), `RW` = clog2(`INPUT_SIZE`)):
- `clk` input 1 — single clock, rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `row_valid` input 1 — upstream has a completed conv row
- `row_ready` output 1 — scheduler can accept a row
- `frame_restart` input 1 — synchronous abort/restart of the frame
- `input_valid` output 1 — one-cycle issue strobe to pooling
- `feature_idx` output FW — feature map of current issue
- `feature_row` output RW — row index of current issue
- `busy` output 1 — high whenever the state is not IDLE
- `frame_done` output 1 — one-cycle pulse after the last issue window of row `INPUT_SIZE-1`

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - `row_ready` = 1, combinational from state.
  - Accept happens on `row_valid && row_ready`; the next state is ISSUE and `feature_idx` is set to 0.
- ISSUE:
  - Lasts one cycle with `input_valid` = 1; the next state is WAIT.
- WAIT:
  - A gap counter runs for `KERNEL_SIZE+3` cycles.
  - On its final cycle, if `feature_idx` < `TOTAL_FEATURE-1`: increment `feature_idx`, next state ISSUE.
  - Otherwise the next state is IDLE.
    - If `feature_row` == `INPUT_SIZE-1`: `feature_row` wraps to 0 and `frame_done` pulses.
    - Otherwise `feature_row` increments.
- `feature_idx`/`feature_row` are registered and held stable from the ISSUE cycle through the last WAIT cycle inclusive. The pooling side samples `feature_idx` in the cycle its `output_valid` is high.
- Rows are always issued in ascending order 0..`INPUT_SIZE-1`. The pooling side's row tracking depends on this order.
- `frame_restart` has the highest priority:
  - Next state is IDLE; `feature_idx` and `feature_row` are cleared to 0; the gap counter is cleared.
  - No `frame_done` is produced.
  - Applies in any state, including the accept cycle; a concurrent accept is dropped.
- `row_valid` outside IDLE is ignored. Upstream holds it until accepted.
- Counters never exceed their terminal values; out-of-range parameter combinations are not supported.

## Timing
- Reset values: state IDLE, `row_ready` 1 (combinational from IDLE), `input_valid` 0, `feature_idx` 0, `feature_row` 0, `busy` 0, `frame_done` 0.
- Accept at cycle t0 gives ISSUE (`input_valid`=1) at t0+1.
- Issue-to-issue spacing is exactly `KERNEL_SIZE+4` cycles (6 at defaults).
- Row occupancy is 1 + `TOTAL_FEATURE`×(`KERNEL_SIZE+4`) cycles including the accept cycle (25 at defaults).
- `frame_done` asserts in the first IDLE cycle after the final WAIT of row `INPUT_SIZE-1`.
- The earliest next accept is that same IDLE cycle, so back-to-back rows have no extra bubble.
- Reset asserted mid-operation immediately forces the reset values, with no pulse on any output.

## Configuration
- `POOL_SCHED_ACK_EN` defined:
  - Adds port `pool_output_valid` (input, 1), driven by the pooling controller's `output_valid`.
  - WAIT ends in the cycle `pool_output_valid` is high instead of on the gap count.
  - The gap counter is not instantiated.
  - A `pool_output_valid` in any state other than WAIT is ignored.
- `POOL_SCHED_ACK_EN` undefined:
  - No `pool_output_valid` port; the fixed `KERNEL_SIZE+3`-cycle WAIT is used.
- With the matching pooling controller, both modes produce identical cycle timing.

## Structure
- Shared package `pooling_pkg`:
  - the state enum (IDLE/ISSUE/WAIT);
  - the `clog2`-style width function;
  - the `ISSUE_GAP` = `KERNEL_SIZE+4` derivation.
- Sub-module `pool_gap_timer`:
  - a loadable down-counter with start, clear and `done` outputs;
  - compiled out under `POOL_SCHED_ACK_EN`.

## Test plan
- Reset release with `row_valid`=0: `row_ready`=1, all other outputs 0, state stays IDLE indefinitely.
- One row accepted at cycle 10 (defaults):
  - `input_valid` pulses at cycles 11, 17, 23, 29 with `feature_idx` 0,1,2,3 and `feature_row`=0;
  - `row_ready` returns to 1 at cycle 35.
- Six rows streamed with `row_valid` held high:
  - `feature_row` steps 0..5, then wraps to 0;
  - one `frame_done` pulse in the IDLE cycle after row 5's last WAIT;
  - 24 total issues.
- `frame_restart` on the cycle of the feature-2 issue of row 3: state goes to IDLE next cycle, `feature_idx`=0, `feature_row`=0, no `frame_done`; the next accepted row issues as row 0.
- `rst_n` pulsed low mid-WAIT: all outputs go to reset values asynchronously, and no spurious `input_valid` follows.
- Under `POOL_SCHED_ACK_EN`, with `pool_output_valid` delayed to 8 cycles after each issue:
  - issue spacing becomes 9 cycles;
  - a stray `pool_output_valid` in IDLE has no effect.

Source files
------------

// File: rtl/pooling_pkg.sv
// rtl/pooling_pkg.sv - shared state encoding and width/gap helpers for the pooling row scheduler
package pooling_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } pool_state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

  // Cycles from one issue strobe to the next: one ISSUE plus kernel+3 WAIT cycles.
  function automatic int issue_gap(input int kernel_size);
    return kernel_size + 4;
  endfunction

endpackage

// File: rtl/pool_gap_timer.sv
// rtl/pool_gap_timer.sv - loadable down-counter timing the WAIT window between issues
module pool_gap_timer
  import pooling_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          clear,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] count_q;

  // Load on start, then count down to zero and hold; clear wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (start) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/pooling_row_scheduler.sv
// rtl/pooling_row_scheduler.sv - issues each accepted conv row once per feature map; POOL_SCHED_ACK_EN ends WAIT on pool_output_valid
module pooling_row_scheduler
  import pooling_pkg::*;
#(
  parameter int INPUT_SIZE    = 6,
  parameter int KERNEL_SIZE   = 2,
  parameter int TOTAL_FEATURE = 4,
  localparam int FW = clog2w(TOTAL_FEATURE),
  localparam int RW = clog2w(INPUT_SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          row_valid,
  output logic          row_ready,
  input  logic          frame_restart,
  output logic          input_valid,
  output logic [FW-1:0] feature_idx,
  output logic [RW-1:0] feature_row,
  output logic          busy,
  output logic          frame_done
`ifdef POOL_SCHED_ACK_EN
  ,
  input  logic          pool_output_valid
`endif
);

  pool_state_e state_q, state_d;
  logic        wait_done;
  logic        idx_last;
  logic        row_last;

  assign idx_last = (feature_idx == FW'(TOTAL_FEATURE - 1));
  assign row_last = (feature_row == RW'(INPUT_SIZE - 1));

`ifdef POOL_SCHED_ACK_EN
  // The pooling controller's compare-window completion closes the WAIT window.
  assign wait_done = pool_output_valid;
`else
  localparam int            GW       = clog2w(issue_gap(KERNEL_SIZE));
  localparam logic [GW-1:0] GAP_LOAD = GW'(issue_gap(KERNEL_SIZE) - 2);

  pool_gap_timer #(
    .CW(GW)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (state_q == ST_ISSUE),
    .clear    (frame_restart),
    .load_val (GAP_LOAD),
    .done     (wait_done)
  );
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: restart dominates, row_valid only matters in IDLE.
  always_comb begin
    state_d = state_q;
    if (frame_restart) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (row_valid) state_d = ST_ISSUE;
        ST_ISSUE: state_d = ST_WAIT;
        ST_WAIT:  if (wait_done) state_d = idx_last ? ST_IDLE : ST_ISSUE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded purely from the current state.
  always_comb begin
    row_ready   = 1'b0;
    input_valid = 1'b0;
    busy        = 1'b1;
    case (state_q)
      ST_IDLE: begin
        row_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_ISSUE: input_valid = 1'b1;
      default: ;
    endcase
  end

  // Feature/row indices advance only at window ends so they stay stable from ISSUE through WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feature_idx <= '0;
      feature_row <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_restart) begin
        feature_idx <= '0;
        feature_row <= '0;
      end else begin
        case (state_q)
          ST_IDLE: if (row_valid) feature_idx <= '0;
          ST_WAIT: begin
            if (wait_done) begin
              if (!idx_last) begin
                feature_idx <= feature_idx + 1'b1;
              end else if (row_last) begin
                feature_row <= '0;
                frame_done  <= 1'b1;
              end else begin
                feature_row <= feature_row + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pooling_row_scheduler.sv
// tb/tb_pooling_row_scheduler.sv - self-checking bench for pooling_row_scheduler
module tb_pooling_row_scheduler;

  localparam int IS     = 6;
  localparam int KS     = 2;
  localparam int TF     = 4;
  localparam int GAP    = KS + 4;
  localparam int ROWLEN = TF * GAP;

  logic       clk;
  logic       rst_n;
  logic       row_valid;
  logic       row_ready;
  logic       frame_restart;
  logic       input_valid;
  logic [1:0] feature_idx;
  logic [2:0] feature_row;
  logic       busy;
  logic       frame_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int iss_cyc[$];
  int iss_idx[$];
  int iss_row[$];
  int fd_cyc[$];
  int rdy_rise = -1;
  bit prev_rdy = 1'b1;

  bit m_busy = 1'b0;
  int m_off  = 0;
  int m_row  = 0;
  int m_idx  = 0;
  bit m_fd   = 1'b0;

`ifdef POOL_SCHED_ACK_EN
  logic       pool_output_valid;
  logic [4:0] ack_sr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_sr <= '0;
    else if (frame_restart) ack_sr <= '0;
    else ack_sr <= {ack_sr[3:0], input_valid};
  end
  assign pool_output_valid = ack_sr[4];
`endif

  pooling_row_scheduler #(
    .INPUT_SIZE   (IS),
    .KERNEL_SIZE  (KS),
    .TOTAL_FEATURE(TF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .row_valid    (row_valid),
    .row_ready    (row_ready),
    .frame_restart(frame_restart),
    .input_valid  (input_valid),
    .feature_idx  (feature_idx),
    .feature_row  (feature_row),
    .busy         (busy),
    .frame_done   (frame_done)
`ifdef POOL_SCHED_ACK_EN
    ,
    .pool_output_valid(pool_output_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: a row occupies offsets 1..ROWLEN after its accept cycle;
  // every GAP-th offset is an issue, and the feature index is the offset's GAP bucket.
  always @(negedge clk) begin
    int e_idx, e_iv, e_busy, e_rdy, e_fd;
    if (!rst_n) begin
      m_busy = 1'b0; m_off = 0; m_row = 0; m_idx = 0; m_fd = 1'b0;
    end
    if (m_busy) begin
      e_idx = (m_off - 1) / GAP;
      e_iv  = ((m_off - 1) % GAP == 0) ? 1 : 0;
      e_busy = 1; e_rdy = 0; e_fd = 0;
    end else begin
      e_idx = m_idx; e_iv = 0; e_busy = 0; e_rdy = 1; e_fd = m_fd ? 1 : 0;
    end
    chk("input_valid", int'(input_valid), e_iv);
    chk("row_ready",   int'(row_ready),   e_rdy);
    chk("busy",        int'(busy),        e_busy);
    chk("frame_done",  int'(frame_done),  e_fd);
    chk("feature_idx", int'(feature_idx), e_idx);
    chk("feature_row", int'(feature_row), m_row);

    if (rst_n) begin
      if (input_valid) begin
        iss_cyc.push_back(cyc);
        iss_idx.push_back(int'(feature_idx));
        iss_row.push_back(int'(feature_row));
      end
      if (frame_done) fd_cyc.push_back(cyc);
      if (row_ready && !prev_rdy) rdy_rise = cyc;
      prev_rdy = row_ready;

      m_fd = 1'b0;
      if (frame_restart) begin
        m_busy = 1'b0; m_row = 0; m_idx = 0;
      end else if (!m_busy) begin
        if (row_valid) begin
          m_busy = 1'b1; m_off = 1;
        end
      end else begin
        m_off = m_off + 1;
        if (m_off > ROWLEN) begin
          m_busy = 1'b0;
          m_idx  = TF - 1;
          m_fd   = (m_row == IS - 1);
          m_row  = (m_row + 1) % IS;
        end
      end
    end else begin
      prev_rdy = 1'b1;
    end
  end

  initial begin
    int a;
    rst_n = 1'b0;
    row_valid = 1'b0;
    frame_restart = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step(10);
    chk("rst_row_ready",   int'(row_ready),   1);
    chk("rst_input_valid", int'(input_valid), 0);
    chk("rst_busy",        int'(busy),        0);
    chk("rst_frame_done",  int'(frame_done),  0);
    chk("rst_feature_idx", int'(feature_idx), 0);
    chk("rst_feature_row", int'(feature_row), 0);

    // Single row.
    iss_cyc.delete(); iss_idx.delete(); iss_row.delete(); fd_cyc.delete();
    a = cyc;
    row_valid = 1'b1;
    step(1);
    row_valid = 1'b0;
    step(30);
    chk("row1_issue_count", iss_cyc.size(), 4);
    for (int i = 0; i < 4 && i < iss_cyc.size(); i++) begin
      chk("row1_issue_cycle", iss_cyc[i] - a, 1 + 6 * i);
      chk("row1_issue_idx", iss_idx[i], i);
      chk("row1_issue_row", iss_row[i], 0);
    end
    chk("row1_ready_return", rdy_rise - a, 25);

    frame_restart = 1'b1;
    step(1);
    frame_restart = 1'b0;
    step(2);

    // Full frame streamed back-to-back.
    iss_cyc.delete(); iss_idx.delete(); iss_row.delete(); fd_cyc.delete();
    a = cyc;
    row_valid = 1'b1;
    step(130);
    row_valid = 1'b0;
    step(30);
    chk("frame_issue_count", iss_cyc.size(), 24);
    for (int i = 0; i < 24 && i < iss_cyc.size(); i++) begin
      chk("frame_issue_cycle", iss_cyc[i] - a, 25 * (i / 4) + 1 + 6 * (i % 4));
      chk("frame_issue_row", iss_row[i], i / 4);
      chk("frame_issue_idx", iss_idx[i], i % 4);
    end
    chk("frame_done_count", fd_cyc.size(), 1);
    if (fd_cyc.size() > 0) chk("frame_done_cycle", fd_cyc[0] - a, 150);
    chk("frame_wrap_row", int'(feature_row), 0);

    // Restart on the feature-2 issue of row 3.
    iss_cyc.delete(); iss_idx.delete(); iss_row.delete(); fd_cyc.delete();
    a = cyc;
    row_valid = 1'b1;
    step(88);
    chk("restart_at_issue", int'(input_valid), 1);
    frame_restart = 1'b1;
    row_valid = 1'b0;
    step(1);
    frame_restart = 1'b0;
    chk("restart_busy", int'(busy), 0);
    chk("restart_idx", int'(feature_idx), 0);
    chk("restart_row", int'(feature_row), 0);
    step(30);
    chk("restart_no_done", fd_cyc.size(), 0);
    chk("restart_issue_count", iss_cyc.size(), 15);
    iss_cyc.delete(); iss_idx.delete(); iss_row.delete();
    row_valid = 1'b1;
    step(1);
    row_valid = 1'b0;
    step(30);
    chk("after_restart_count", iss_row.size(), 4);
    if (iss_row.size() > 0) chk("after_restart_row", iss_row[0], 0);

    // Asynchronous reset in the middle of WAIT.
    row_valid = 1'b1;
    step(1);
    row_valid = 1'b0;
    step(3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy",        int'(busy),        0);
    chk("async_row_ready",   int'(row_ready),   1);
    chk("async_input_valid", int'(input_valid), 0);
    chk("async_idx",         int'(feature_idx), 0);
    chk("async_row",         int'(feature_row), 0);
    chk("async_frame_done",  int'(frame_done),  0);
    step(2);
    iss_cyc.delete(); iss_idx.delete(); iss_row.delete();
    rst_n = 1'b1;
    step(20);
    chk("async_no_issue", iss_cyc.size(), 0);

    // Randomized traffic with occasional restarts.
    for (int i = 0; i < 3000; i++) begin
      row_valid     = ($urandom_range(0, 3) != 0);
      frame_restart = ($urandom_range(0, 149) == 0);
      step(1);
    end
    row_valid = 1'b0;
    frame_restart = 1'b0;
    step(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
